// File: rtl/poly_constraint_pkg.sv
// Shared types, default parameters and width helpers for the sequential
// polynomial constraint checker.
package poly_constraint_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      CMP  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int DEF_N_X   = 3;
   localparam int DEF_XW    = 12;
   localparam int DEF_N_Y   = 3;
   localparam int DEF_YW    = 22;
   localparam int DEF_K_LO  = 3;
   localparam int DEF_K_MUL = 9;

   // Width of an unsigned sum of n operands of w bits each.
   function automatic int sum_width(input int w, input int n);
      return w + $clog2(n);
   endfunction

   // Comparison width: wide enough for Q and for K_MUL*T + 1 without wrap.
   function automatic int cmp_width(input int qw, input int tw, input int k_mul);
      int rhs_w;
      rhs_w = tw + $clog2(k_mul) + 1;
      return ((qw > rhs_w) ? qw : rhs_w) + 1;
   endfunction

endpackage

// File: rtl/poly_serial_sq.sv
// Bit-serial shift-add squarer: start_i loads the operand, then one
// multiplier bit is processed per cycle (LSB first) for exactly SW cycles.
module poly_serial_sq
   import poly_constraint_pkg::*;
#(
   parameter int SW = 14
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [SW-1:0]   op_i,
   output logic            done_o,
   output logic [2*SW-1:0] q_o
);

   localparam int QW   = 2 * SW;
   localparam int CNTW = $clog2(SW + 1);

   logic [SW-1:0]   op_q,  op_d;
   logic [QW-1:0]   acc_q, acc_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            run_q, run_d;
   logic            last;

   // The final bit is being added this cycle; acc_q holds Q on the next one.
   assign last   = run_q && (cnt_q == CNTW'(SW - 1));
   assign done_o = last;
   assign q_o    = acc_q;

   // NOTE: every next-state value is defaulted to its register first, so no
   // path through this block can leave a signal unassigned and infer a latch.
   always_comb begin
      op_d  = op_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (start_i) begin
         op_d  = op_i;
         acc_d = '0;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         if (op_q[cnt_q]) begin
            acc_d = acc_q + (QW'(op_q) << cnt_q);
         end
         cnt_d = cnt_q + CNTW'(1);
         if (last) begin
            run_d = 1'b0;
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q  <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         op_q  <= op_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule

// File: rtl/poly_constraint_seq.sv
// Sequential polynomial constraint checker: Q = sum(x)^2 compared against
// T = sum(y). Optional saturating mismatch counter under POLY_MISMATCH_CNT_EN.
module poly_constraint_seq
   import poly_constraint_pkg::*;
#(
   parameter int N_X   = DEF_N_X,
   parameter int XW    = DEF_XW,
   parameter int N_Y   = DEF_N_Y,
   parameter int YW    = DEF_YW,
   parameter int K_LO  = DEF_K_LO,
   parameter int K_MUL = DEF_K_MUL
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N_X*XW-1:0] in_x,
   input  logic [N_Y*YW-1:0] in_y,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_match,
   output logic            out_lhs,
   output logic            out_rhs,
   output logic            busy
`ifdef POLY_MISMATCH_CNT_EN
   ,
   output logic [15:0]     mismatch_cnt
`endif
);

   localparam int SW = sum_width(XW, N_X);
   localparam int TW = sum_width(YW, N_Y);
   localparam int QW = 2 * SW;
   localparam int CW = cmp_width(QW, TW, K_MUL);

   localparam logic [TW-1:0] K_LO_T  = TW'(K_LO);
   localparam logic [CW-1:0] K_MUL_C = CW'(K_MUL);

   state_e          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic            lhs_q, lhs_d;
   logic            rhs_q, rhs_d;
   logic            match_q, match_d;

   logic [SW-1:0]   s_sum;
   logic [TW-1:0]   t_sum;
   logic            accept;
   logic            sq_done;
   logic [QW-1:0]   sq_q;
   logic [CW-1:0]   q_ext, lo_bound, mul_bound;

   always_comb begin
      s_sum = '0;
      for (int i = 0; i < N_X; i++) begin
         s_sum = s_sum + SW'(in_x[i*XW +: XW]);
      end
      t_sum = '0;
      for (int i = 0; i < N_Y; i++) begin
         t_sum = t_sum + TW'(in_y[i*YW +: YW]);
      end
   end

   assign accept = (state_q == IDLE) && in_valid;

   poly_serial_sq #(
      .SW (SW)
   ) u_sq (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (accept),
      .op_i    (s_sum),
      .done_o  (sq_done),
      .q_o     (sq_q)
   );

   // Both bounds evaluated at CW bits, so neither T+1 nor K_MUL*T can wrap.
   assign q_ext     = CW'(sq_q);
   assign lo_bound  = CW'(t_q) + CW'(t_q < K_LO_T);
   assign mul_bound = CW'(t_q) * K_MUL_C;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      lhs_d   = lhs_q;
      rhs_d   = rhs_q;
      match_d = match_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               t_d     = t_sum;
               state_d = MUL;
            end
         end
         MUL: begin
            if (sq_done) begin
               state_d = CMP;
            end
         end
         CMP: begin
            lhs_d   = q_ext < lo_bound;
            rhs_d   = q_ext < mul_bound;
            match_d = (lhs_d == rhs_d);
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         t_q     <= '0;
         lhs_q   <= 1'b0;
         rhs_q   <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         lhs_q   <= lhs_d;
         rhs_q   <= rhs_d;
         match_q <= match_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_lhs   = lhs_q;
   assign out_rhs   = rhs_q;
   assign out_match = match_q;

`ifdef POLY_MISMATCH_CNT_EN
   logic [15:0] mm_cnt_q, mm_cnt_d;

   always_comb begin
      mm_cnt_d = mm_cnt_q;
      if (out_valid && out_ready && !match_q && (mm_cnt_q != 16'hFFFF)) begin
         mm_cnt_d = mm_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mm_cnt_q <= '0;
      end else begin
         mm_cnt_q <= mm_cnt_d;
      end
   end

   assign mismatch_cnt = mm_cnt_q;
`endif

endmodule

// File: doc/poly_constraint_seq.md
Name: poly_constraint_seq

Overview:
- Sequential, parametrised successor to the combinational polynomial constraint checker.
- Accepts N_X "x" operands and N_Y "y" operands over a valid/ready handshake.
- Computes S = sum(x), T = sum(y) and Q = S*S using a bit-serial shift-add multiplier.
- Evaluates two predicates, LHS: Q < T + (T < K_LO) and RHS: Q < K_MUL*T, then reports match = (LHS == RHS).
- Sits between the stimulus generator and the scoreboard in the linear-constraint test harness.

Parameters:
- N_X, 3, number of x operands
- XW, 12, width of each x operand
- N_Y, 3, number of y operands
- YW, 22, width of each y operand
- K_LO, 3, threshold for the T-small correction term
- K_MUL, 9, multiplier for the RHS bound (must be >= 1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept a bundle
- in_x  in  N_X*XW  packed x operands; x[i] = in_x[i*XW +: XW]
- in_y  in  N_Y*YW  packed y operands, same packing
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_match  out  1  LHS == RHS
- out_lhs  out  1  LHS predicate
- out_rhs  out  1  RHS predicate
- busy  out  1  state != IDLE

Behaviour:
- Reset: one clock and a synchronous active-low reset; rst_n low on a rising clk edge forces state IDLE, in_ready=1, out_valid=0, out_match=0, out_lhs=0, out_rhs=0, busy=0. All datapath registers are cleared.
- Reset mid-operation: any in-flight bundle is dropped and no result is emitted.
- Widths (all arithmetic unsigned, zero-extended, no overflow possible):
  - SW = XW + clog2(N_X)
  - TW = YW + clog2(N_Y)
  - QW = 2*SW
  - CW = max(QW, TW + clog2(K_MUL) + 1) + 1
- States: IDLE, MUL, CMP, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: register S and T (adder trees), clear accumulator and bit counter, go to MUL.
- MUL:
  - One multiplier bit per cycle, LSB first: if S[cnt] then acc += S << cnt.
  - Exactly SW cycles, then go to CMP.
  - in_ready = 0.
- CMP:
  - Single cycle at width CW: lhs = acc < T + (T < K_LO); rhs = acc < K_MUL*T.
  - Register out_lhs, out_rhs, out_match; go to DONE.
- DONE:
  - out_valid = 1; outputs held stable while out_ready = 0.
  - On out_ready: out_valid drops next cycle and state returns to IDLE.
  - in_ready stays 0 in DONE; no overlap.
- Latency: acceptance edge E0; out_valid is high after edge E0+SW+1 (defaults: 15 cycles).
- Throughput: at best one bundle per SW+3 cycles.
- Inputs are sampled only on the acceptance edge; later changes to in_x/in_y have no effect.
- in_valid while busy is ignored (in_ready = 0); the source must hold the bundle.
- Zero operands: S = 0 skips no cycles; the MUL count is fixed at SW.
- Maximum operands: exact result; CW guarantees no wrap.

Optional Feature:
- Macro POLY_MISMATCH_CNT_EN.
- When defined:
  - Adds output mismatch_cnt (16 bits).
  - Increments on each DONE handshake (out_valid & out_ready) where out_match = 0.
  - Saturates at 0xFFFF; cleared by reset.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package poly_constraint_pkg holds:
  - state enum (IDLE, MUL, CMP, DONE)
  - width helper functions (sum width, CW calculation)
  - default parameter constants
- One sub-module, poly_serial_sq: bit-serial squarer with start/done, parameter SW, output QW bits. The FSM in poly_constraint_seq sequences it.
- Adder trees and comparators stay inline.

Test Plan:
1. x=(1,1,1), y=(1,1,1): S=3, Q=9, T=3, correction=0 -> lhs=0 (9<3 false), rhs=1 (9<27), match=0, out_valid at edge E0+15.
2. x=(0,0,0), y=(0,0,0): T=0<3 -> lhs=1 (0<1), rhs=0 (0<0), match=0.
3. x=(0,0,0), y=(1,0,0): T=1 -> lhs=1 (0<2), rhs=1 (0<9), match=1.
4. x all 4095, y all 4194303: Q=150921225, T=12582909, 9T=113246181 -> lhs=0, rhs=0, match=1; no wrap.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, second in_valid is not accepted. Release -> next bundle accepted exactly one cycle after the IDLE return.
6. Assert rst_n=0 for one edge at MUL cycle 5 -> no out_valid, in_ready=1 next cycle. With POLY_MISMATCH_CNT_EN, running scenarios 1, 2 then 3 -> mismatch_cnt=2.
